mem_dispatcher__write: RTL
==========================

Name: mem_dispatcher__write

Overview:
Upstream counterpart of the read dispatcher. On a start pulse it fetches WORDS_TO_WRITE words from a local on-chip buffer with 1-cycle read latency, pushes them into the external-memory controller write FIFO, and issues burst write commands of up to FIFO_LENGTH words. It stores processed frame lines back to external memory, where the read dispatcher later reads them.

Parameters:
FIFO_LENGTH, 64, max words per burst (1..64; controller FIFO depth)
WORDS_TO_WRITE, 640, total words per transfer (>=1)
BUFF_ADDR_BITS, 0, local buffer address width; 0 means ceil_log2(WORDS_TO_WRITE-1)
PORT_64_BITS, 0, 1 selects 64-bit port (8 bytes/word), 0 selects 32-bit (4 bytes/word)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
os_start  in  1  one-cycle start pulse; honoured only in IDLE
init_mem_addr  in  30  external byte address of first word
busy_write_unit  out  1  high except in IDLE
data_in__addr  out  ADDR_IN_BITS  local buffer read address
data_in  in  MEM_PORT_BITS  buffer data, valid 1 cycle after address
mem_calib_done  in  1  controller calibration complete
port_cmd_en  out  1  command strobe, one cycle per burst
port_cmd_instr  out  3  constant 3'b000 (write)
port_cmd_bl  out  6  burst length minus 1
port_cmd_byte_addr  out  30  burst start byte address
port_cmd_full  in  1  command FIFO full
port_wr_en  out  1  write-FIFO push
port_wr_data  out  MEM_PORT_BITS  pushed word
port_wr_mask  out  MEM_PORT_BITS/8  constant all-zero (all bytes written)
port_wr_full  in  1  write FIFO full
port_wr_empty  in  1  write FIFO empty

Behaviour:
- Reset (async, rst_n=0): state=WAIT_CALIB; busy_write_unit=1; port_cmd_en=0; port_wr_en=0; port_cmd_bl=0; port_cmd_byte_addr=0; data_in__addr=0; all counters and the skid buffer are cleared. Reset mid-transfer abandons the transfer with no further commands. Words already pushed stay in the controller.
- WORD_BYTES = 4 or 8. BURST_STEP = FIFO_LENGTH*WORD_BYTES. Address arithmetic is 30-bit with silent wrap.
- WAIT_CALIB: stay until mem_calib_done=1, then go to IDLE.
- IDLE: busy=0. On os_start, latch cmd_addr=init_mem_addr, remaining=WORDS_TO_WRITE, fetch address=0, then go to FILL.
- FILL: burst_len = min(remaining, FIFO_LENGTH).
  - Issue buffer reads at consecutive addresses until burst_len reads are done.
  - Returned words enter a 2-entry skid buffer.
  - Issue a read only if (occupancy + reads in flight) < 2, counting a pop in the same cycle.
  - port_wr_en = skid nonempty AND !port_wr_full; port_wr_data = skid head. No word is lost or duplicated under any port_wr_full pattern.
  - When burst_len words have been pushed, go to CMD.
- CMD: wait while port_cmd_full=1. When it is 0, pulse port_cmd_en for exactly 1 cycle with port_cmd_bl=burst_len-1 and port_cmd_byte_addr=cmd_addr. Then cmd_addr += BURST_STEP and remaining -= burst_len.
  - If remaining > 0, go to FILL.
  - Otherwise go to FLUSH.
- FLUSH: wait for port_wr_empty=1, then go to IDLE.
- Throughput: with no backpressure, 1 word per cycle in FILL after 2-cycle pipeline fill.
- os_start outside IDLE is ignored.
- A command is never issued before all of its words are in the write FIFO.
- port_cmd_instr and port_wr_mask are constants.

Decomposition:
- Shared package (mem_dispatcher_pkg): READ_CMD=3'b001, WRITE_CMD=3'b000, ceil_log2 function, and WORD_BYTES/BURST_STEP derivation shared with the read dispatcher.
- One sub-module: mem_wr_skid2 (2-entry skid FIFO with push/pop/count, async active-low reset).

Test Plan:
- Defaults, init_mem_addr=0x1000, no backpressure: 640 words pushed in order; 10 commands at 0x1000, 0x1100 … 0x1900, each bl=63; busy drops after port_wr_empty; data matches buffer contents.
- WORDS_TO_WRITE=100, PORT_64_BITS=1, init=0x2000: commands (0x2000, bl=63) then (0x2200, bl=35); exactly 100 pushes.
- Random port_wr_full (~50%): push sequence identical to the no-stall case; no drop or duplicate; never port_wr_en while full.
- port_cmd_full held high 20 cycles at the first CMD: port_cmd_en is delayed until release, then pulses once; no extra pushes occur meanwhile.
- rst_n low mid-burst, then mem_calib_done low: outputs take reset values immediately; FSM waits in WAIT_CALIB; a new os_start after calibration completes a clean transfer.
- os_start pulsed during FILL: ignored; command count and addresses unchanged.

Source files
------------

// File: rtl/mem_dispatcher_pkg.sv
// rtl/mem_dispatcher_pkg.sv - shared constants and helpers for the memory dispatchers
package mem_dispatcher_pkg;

  localparam logic [2:0] READ_CMD  = 3'b001;
  localparam logic [2:0] WRITE_CMD = 3'b000;

  typedef enum logic [2:0] {
    ST_WAIT_CALIB,
    ST_IDLE,
    ST_FILL,
    ST_CMD,
    ST_FLUSH
  } wr_state_t;

  // Number of bits needed to hold the value v (never less than 1), so a
  // buffer index range 0..v fits.
  function automatic int ceil_log2(input int v);
    int r;
    r = 1;
    while ((v >> r) != 0) r++;
    return r;
  endfunction

  function automatic int word_bytes(input int port_64_bits);
    return (port_64_bits != 0) ? 8 : 4;
  endfunction

  // Byte distance between consecutive full bursts.
  function automatic int burst_step(input int fifo_length, input int port_64_bits);
    return fifo_length * word_bytes(port_64_bits);
  endfunction

endpackage

// File: rtl/mem_wr_skid2.sv
// rtl/mem_wr_skid2.sv - 2-entry skid FIFO between buffer read data and write port
module mem_wr_skid2 #(
  parameter int DATA_BITS = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 push,
  input  logic [DATA_BITS-1:0] push_data,
  input  logic                 pop,
  output logic [DATA_BITS-1:0] head_data,
  output logic [1:0]           count
);

  logic [DATA_BITS-1:0] slot0_q, slot0_d;
  logic [DATA_BITS-1:0] slot1_q, slot1_d;
  logic                 rd_ptr_q, rd_ptr_d;
  logic                 wr_ptr_q, wr_ptr_d;
  logic [1:0]           count_q, count_d;

  // Next-state: the caller never pushes when full nor pops when empty.
  always_comb begin
    slot0_d  = slot0_q;
    slot1_d  = slot1_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    if (push) begin
      if (wr_ptr_q) slot1_d = push_data;
      else          slot0_d = push_data;
      wr_ptr_d = ~wr_ptr_q;
    end
    if (pop) rd_ptr_d = ~rd_ptr_q;
    count_d = count_q + {1'b0, push} - {1'b0, pop};
  end

  // State registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot0_q  <= '0;
      slot1_q  <= '0;
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      slot0_q  <= slot0_d;
      slot1_q  <= slot1_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  assign head_data = rd_ptr_q ? slot1_q : slot0_q;
  assign count     = count_q;

endmodule

// File: rtl/mem_dispatcher__write.sv
// rtl/mem_dispatcher__write.sv - streams a local buffer into external memory as burst writes
module mem_dispatcher__write
  import mem_dispatcher_pkg::*;
#(
  parameter int FIFO_LENGTH    = 64,
  parameter int WORDS_TO_WRITE = 640,
  parameter int BUFF_ADDR_BITS = 0,
  parameter int PORT_64_BITS   = 0,
  localparam int ADDR_IN_BITS  = (BUFF_ADDR_BITS == 0) ? ceil_log2(WORDS_TO_WRITE - 1) : BUFF_ADDR_BITS,
  localparam int MEM_PORT_BITS = (PORT_64_BITS != 0) ? 64 : 32
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       os_start,
  input  logic [29:0]                init_mem_addr,
  output logic                       busy_write_unit,
  output logic [ADDR_IN_BITS-1:0]    data_in__addr,
  input  logic [MEM_PORT_BITS-1:0]   data_in,
  input  logic                       mem_calib_done,
  output logic                       port_cmd_en,
  output logic [2:0]                 port_cmd_instr,
  output logic [5:0]                 port_cmd_bl,
  output logic [29:0]                port_cmd_byte_addr,
  input  logic                       port_cmd_full,
  output logic                       port_wr_en,
  output logic [MEM_PORT_BITS-1:0]   port_wr_data,
  output logic [MEM_PORT_BITS/8-1:0] port_wr_mask,
  input  logic                       port_wr_full,
  input  logic                       port_wr_empty
);

  // Counters must hold both the full word count and a full burst length.
  localparam int CNT_BITS = (ceil_log2(WORDS_TO_WRITE) > 7) ? ceil_log2(WORDS_TO_WRITE) : 7;
  localparam logic [CNT_BITS-1:0] FIFO_LEN_C = CNT_BITS'(FIFO_LENGTH);
  localparam logic [CNT_BITS-1:0] WORDS_C    = CNT_BITS'(WORDS_TO_WRITE);
  localparam logic [29:0]         STEP_C     = 30'(burst_step(FIFO_LENGTH, PORT_64_BITS));

  wr_state_t             state_q, state_d;
  logic                  busy_q, busy_d;
  logic                  cmd_en_q, cmd_en_d;
  logic [5:0]            cmd_bl_q, cmd_bl_d;
  logic [29:0]           cmd_out_addr_q, cmd_out_addr_d;
  logic [29:0]           cmd_addr_q, cmd_addr_d;
  logic [ADDR_IN_BITS-1:0] fetch_addr_q, fetch_addr_d;
  logic                  rd_valid_q, rd_valid_d;
  logic [CNT_BITS-1:0]   rd_cnt_q, rd_cnt_d;
  logic [CNT_BITS-1:0]   wr_cnt_q, wr_cnt_d;
  logic [CNT_BITS-1:0]   burst_len_q, burst_len_d;
  logic [CNT_BITS-1:0]   remaining_q, remaining_d;

  logic [MEM_PORT_BITS-1:0] skid_head;
  logic [1:0]            skid_count;
  logic                  pop;
  logic                  issue;
  logic [2:0]            occ;
  logic [CNT_BITS-1:0]   rem_next;

  mem_wr_skid2 #(.DATA_BITS(MEM_PORT_BITS)) u_skid (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (rd_valid_q),
    .push_data (data_in),
    .pop       (pop),
    .head_data (skid_head),
    .count     (skid_count)
  );

  // Write-port handshake and read-issue throttle: a read is allowed only if
  // the skid buffer can still absorb it once every in-flight word lands.
  always_comb begin
    pop   = (state_q == ST_FILL) && (skid_count != 2'd0) && !port_wr_full;
    occ   = {1'b0, skid_count} + {2'b00, rd_valid_q} - {2'b00, pop};
    issue = (state_q == ST_FILL) && (rd_cnt_q != burst_len_q) && (occ < 3'd2);
  end

  // Dispatcher sequencing: calibrate, fetch a burst, command it, flush.
  always_comb begin
    state_d        = state_q;
    cmd_en_d       = 1'b0;
    cmd_bl_d       = cmd_bl_q;
    cmd_out_addr_d = cmd_out_addr_q;
    cmd_addr_d     = cmd_addr_q;
    fetch_addr_d   = fetch_addr_q;
    rd_valid_d     = issue;
    rd_cnt_d       = rd_cnt_q;
    wr_cnt_d       = wr_cnt_q;
    burst_len_d    = burst_len_q;
    remaining_d    = remaining_q;
    rem_next       = remaining_q - burst_len_q;
    case (state_q)
      ST_WAIT_CALIB: if (mem_calib_done) state_d = ST_IDLE;
      ST_IDLE: begin
        if (os_start) begin
          cmd_addr_d   = init_mem_addr;
          remaining_d  = WORDS_C;
          fetch_addr_d = '0;
          rd_cnt_d     = '0;
          wr_cnt_d     = '0;
          burst_len_d  = (WORDS_C > FIFO_LEN_C) ? FIFO_LEN_C : WORDS_C;
          state_d      = ST_FILL;
        end
      end
      ST_FILL: begin
        if (issue) begin
          fetch_addr_d = fetch_addr_q + ADDR_IN_BITS'(1);
          rd_cnt_d     = rd_cnt_q + CNT_BITS'(1);
        end
        if (pop) begin
          wr_cnt_d = wr_cnt_q + CNT_BITS'(1);
          if (wr_cnt_d == burst_len_q) state_d = ST_CMD;
        end
      end
      ST_CMD: begin
        if (!port_cmd_full) begin
          cmd_en_d       = 1'b1;
          cmd_bl_d       = 6'(burst_len_q - CNT_BITS'(1));
          cmd_out_addr_d = cmd_addr_q;
          cmd_addr_d     = cmd_addr_q + STEP_C;
          remaining_d    = rem_next;
          rd_cnt_d       = '0;
          wr_cnt_d       = '0;
          burst_len_d    = (rem_next > FIFO_LEN_C) ? FIFO_LEN_C : rem_next;
          state_d        = (rem_next != '0) ? ST_FILL : ST_FLUSH;
        end
      end
      ST_FLUSH: if (port_wr_empty) state_d = ST_IDLE;
      default: state_d = ST_WAIT_CALIB;
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= ST_WAIT_CALIB;
      busy_q         <= 1'b1;
      cmd_en_q       <= 1'b0;
      cmd_bl_q       <= 6'd0;
      cmd_out_addr_q <= 30'd0;
      cmd_addr_q     <= 30'd0;
      fetch_addr_q   <= '0;
      rd_valid_q     <= 1'b0;
      rd_cnt_q       <= '0;
      wr_cnt_q       <= '0;
      burst_len_q    <= '0;
      remaining_q    <= '0;
    end else begin
      state_q        <= state_d;
      busy_q         <= busy_d;
      cmd_en_q       <= cmd_en_d;
      cmd_bl_q       <= cmd_bl_d;
      cmd_out_addr_q <= cmd_out_addr_d;
      cmd_addr_q     <= cmd_addr_d;
      fetch_addr_q   <= fetch_addr_d;
      rd_valid_q     <= rd_valid_d;
      rd_cnt_q       <= rd_cnt_d;
      wr_cnt_q       <= wr_cnt_d;
      burst_len_q    <= burst_len_d;
      remaining_q    <= remaining_d;
    end
  end

  assign busy_write_unit    = busy_q;
  assign data_in__addr      = fetch_addr_q;
  assign port_cmd_en        = cmd_en_q;
  assign port_cmd_instr     = WRITE_CMD;
  assign port_cmd_bl        = cmd_bl_q;
  assign port_cmd_byte_addr = cmd_out_addr_q;
  assign port_wr_en         = pop;
  assign port_wr_data       = skid_head;
  assign port_wr_mask       = '0;

endmodule
